// File: rtl/dnn_train_sequencer.sv
// dnn_train_sequencer: start/pause/done run controller that emits block-cycle phase strobes,
// training-case and epoch indices, and per-epoch correct counts for the DNN datapath.
module dnn_train_sequencer #(
  parameter int cpc            = 18,
  parameter int pipe_delay     = 2,
  parameter int training_cases = 10000,
  parameter int epochs         = 10
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic                                                 start,
  input  logic                                                 pause,
  input  logic                                                 correct_in,
  output logic [$clog2(cpc)-1:0]                               cycle_index,
  output logic                                                 cycle_clk,
  output logic                                                 feed_valid,
  output logic [$clog2((cpc-pipe_delay) > 1 ? cpc-pipe_delay : 2)-1:0] sel_network,
  output logic                                                 out_valid,
  output logic [$clog2((cpc-pipe_delay) > 1 ? cpc-pipe_delay : 2)-1:0] out_index,
  output logic [$clog2(training_cases > 1 ? training_cases : 2)-1:0]   sel_tc,
  output logic [$clog2(epochs+1)-1:0]                          epoch,
  output logic [$clog2(training_cases+1)-1:0]                  epoch_correct,
  output logic                                                 running,
  output logic                                                 done
);
  localparam int CW = $clog2(cpc);
  localparam int SW = $clog2((cpc-pipe_delay) > 1 ? cpc-pipe_delay : 2);
  localparam int TW = $clog2(training_cases > 1 ? training_cases : 2);
  localparam int EW = $clog2(epochs+1);
  localparam int AW = $clog2(training_cases+1);
  localparam logic [CW-1:0] CI_LAST  = CW'(cpc-1);
  localparam logic [CW-1:0] FEED_END = CW'(cpc-pipe_delay);
  localparam logic [CW-1:0] PD       = CW'(pipe_delay);
  localparam logic [TW-1:0] TC_LAST  = TW'(training_cases-1);
  localparam logic [EW-1:0] EP_LAST  = EW'(epochs-1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   ci_n;
  logic [TW-1:0]   tc_n;
  logic [EW-1:0]   ep_n;
  logic [AW-1:0]   acc, acc_n, ec_n;
  logic            run_n, feed_n, out_n;

  always_comb begin
    state_n = state;
    ci_n    = cycle_index;
    tc_n    = sel_tc;
    ep_n    = epoch;
    ec_n    = epoch_correct;
    acc_n   = acc;
    case (state)
      IDLE, DONE: if (start) begin
        state_n = RUN;
        ci_n    = '0;
        tc_n    = '0;
        ep_n    = '0;
        ec_n    = '0;
        acc_n   = '0;
      end
      RUN: if (cycle_index == CI_LAST) begin
        ci_n  = '0;
        acc_n = acc + AW'(correct_in);
        tc_n  = (sel_tc == TC_LAST) ? '0 : sel_tc + TW'(1);
        if (sel_tc == TC_LAST) begin
          ep_n  = epoch + EW'(1);
          ec_n  = acc_n;
          acc_n = '0;
        end
        // completion wins over a pause request on the final boundary
        state_n = (sel_tc == TC_LAST && epoch == EP_LAST) ? DONE : pause ? PAUSE : RUN;
      end else ci_n = cycle_index + CW'(1);
      PAUSE: state_n = pause ? PAUSE : RUN;
      default: ;
    endcase
    run_n  = state_n == RUN;
    feed_n = run_n && ci_n < FEED_END;
    out_n  = run_n && ci_n >= PD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cycle_index   <= '0;
      sel_tc        <= '0;
      epoch         <= '0;
      epoch_correct <= '0;
      acc           <= '0;
      running       <= 1'b0;
      done          <= 1'b0;
      cycle_clk     <= 1'b0;
      feed_valid    <= 1'b0;
      sel_network   <= '0;
      out_valid     <= 1'b0;
      out_index     <= '0;
    end else begin
      state         <= state_n;
      cycle_index   <= ci_n;
      sel_tc        <= tc_n;
      epoch         <= ep_n;
      epoch_correct <= ec_n;
      acc           <= acc_n;
      running       <= run_n;
      done          <= state_n == DONE;
      cycle_clk     <= run_n && ci_n == CI_LAST;
      feed_valid    <= feed_n;
      sel_network   <= feed_n ? SW'(ci_n) : '0;
      out_valid     <= out_n;
      out_index     <= out_n ? SW'(ci_n - PD) : '0;
    end
  end
endmodule

// File: tb/tb_dnn_train_sequencer.sv
// tb_dnn_train_sequencer: directed bench for the run sequencer with cpc=6, pipe_delay=2,
// training_cases=3, epochs=2.
module tb_dnn_train_sequencer;
  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, pause = 1'b0, correct_in = 1'b0;
  logic [2:0] cycle_index;
  logic       cycle_clk, feed_valid, out_valid, running, done;
  logic [1:0] sel_network, out_index, sel_tc, epoch, epoch_correct;
  int         n_cmp = 0, n_err = 0;

  dnn_train_sequencer #(.cpc(6), .pipe_delay(2), .training_cases(3), .epochs(2)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .correct_in(correct_in),
    .cycle_index(cycle_index), .cycle_clk(cycle_clk), .feed_valid(feed_valid),
    .sel_network(sel_network), .out_valid(out_valid), .out_index(out_index),
    .sel_tc(sel_tc), .epoch(epoch), .epoch_correct(epoch_correct),
    .running(running), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic to_last();
    int k = 0;
    while (cycle_index != 3'd5 && k < 20) begin
      step();
      k++;
    end
    chk("to_last", int'(cycle_index), 5);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int n;
    step();
    step();
    chk("rst_running", int'(running), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ci", int'(cycle_index), 0);
    chk("rst_sel_tc", int'(sel_tc), 0);
    chk("rst_feed", int'(feed_valid), 0);
    reset = 1'b0;
    step();
    chk("idle_running", int'(running), 0);

    // full run, correct on every boundary, start ignored mid-run, pause on final boundary
    correct_in = 1'b1;
    pulse_start();
    n = 0;
    while (running && n < 100) begin
      chk("ci_seq", int'(cycle_index), n % 6);
      chk("cycle_clk", int'(cycle_clk), int'(n % 6 == 5));
      if (n < 6) begin
        chk("feed_valid", int'(feed_valid), int'(n < 4));
        chk("sel_network", int'(sel_network), n < 4 ? n : 0);
        chk("out_valid", int'(out_valid), int'(n >= 2));
        chk("out_index", int'(out_index), n >= 2 ? n - 2 : 0);
        chk("sel_tc0", int'(sel_tc), 0);
      end
      if (n == 6) chk("sel_tc1", int'(sel_tc), 1);
      if (n == 18) begin
        chk("ep1_epoch", int'(epoch), 1);
        chk("ep1_correct", int'(epoch_correct), 3);
        chk("ep1_sel_tc", int'(sel_tc), 0);
      end
      start = (n == 8);
      pause = (n == 35);
      step();
      n++;
    end
    start = 1'b0;
    pause = 1'b0;
    chk("run_len", n, 36);
    chk("done", int'(done), 1);
    chk("done_epoch", int'(epoch), 2);
    chk("done_correct", int'(epoch_correct), 3);
    chk("done_sel_tc", int'(sel_tc), 0);
    chk("done_ci", int'(cycle_index), 0);
    step();
    chk("done_hold", int'(done), 1);
    chk("done_feed", int'(feed_valid), 0);

    // restart from DONE; pause mid case 1; correct pattern 1,0,1 then 0,0,0
    correct_in = 1'b0;
    pulse_start();
    chk("restart_done", int'(done), 0);
    chk("restart_running", int'(running), 1);
    chk("restart_epoch", int'(epoch), 0);
    chk("restart_correct", int'(epoch_correct), 0);
    to_last();
    correct_in = 1'b1;
    step();
    correct_in = 1'b0;
    chk("case1_sel_tc", int'(sel_tc), 1);
    step();
    step();
    chk("pause_at_ci", int'(cycle_index), 2);
    pause = 1'b1;
    step();
    chk("pause_ignored_mid", int'(running), 1);
    to_last();
    step();
    chk("paused_running", int'(running), 0);
    chk("paused_sel_tc", int'(sel_tc), 2);
    chk("paused_ci", int'(cycle_index), 0);
    for (int i = 0; i < 3; i++) begin
      chk("paused_feed", int'(feed_valid), 0);
      chk("paused_out", int'(out_valid), 0);
      chk("paused_cclk", int'(cycle_clk), 0);
      step();
    end
    chk("paused_hold_tc", int'(sel_tc), 2);
    pause = 1'b0;
    step();
    chk("resume_running", int'(running), 1);
    chk("resume_ci", int'(cycle_index), 0);
    chk("resume_sel_tc", int'(sel_tc), 2);
    chk("resume_feed", int'(feed_valid), 1);
    chk("pre_wrap_correct", int'(epoch_correct), 0);
    to_last();
    correct_in = 1'b1;
    step();
    correct_in = 1'b0;
    chk("wrap_epoch", int'(epoch), 1);
    chk("wrap_correct", int'(epoch_correct), 2);
    chk("wrap_sel_tc", int'(sel_tc), 0);
    for (int i = 0; i < 3; i++) begin
      to_last();
      step();
    end
    chk("p4_done", int'(done), 1);
    chk("p4_epoch", int'(epoch), 2);
    chk("p4_correct", int'(epoch_correct), 0);

    // asynchronous reset mid run
    pulse_start();
    for (int i = 0; i < 25; i++) step();
    chk("pre_rst_epoch", int'(epoch), 1);
    chk("pre_rst_sel_tc", int'(sel_tc), 1);
    reset = 1'b1;
    #2;
    chk("arst_running", int'(running), 0);
    chk("arst_epoch", int'(epoch), 0);
    chk("arst_sel_tc", int'(sel_tc), 0);
    chk("arst_ci", int'(cycle_index), 0);
    chk("arst_feed", int'(feed_valid), 0);
    chk("arst_out_index", int'(out_index), 0);
    #1;
    reset = 1'b0;
    step();
    chk("post_rst_idle", int'(running), 0);
    pulse_start();
    chk("post_rst_running", int'(running), 1);
    chk("post_rst_sel_tc", int'(sel_tc), 0);
    chk("post_rst_epoch", int'(epoch), 0);
    chk("post_rst_ci", int'(cycle_index), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
